// File: rtl/matrix_scanner.sv
// Row-strobe / column-sense scanner for the board sensor matrix with whole-frame
// debounce and a valid/ready publish port carrying the stable board plus change mask.
module matrix_scanner #(
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int SETTLE   = 1,
   parameter int DEBOUNCE = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [COLS-1:0]      c,
   output logic [ROWS-1:0]      r,
   output logic [ROWS*COLS-1:0] frame,
   output logic [ROWS*COLS-1:0] change_mask,
   output logic                 frame_valid,
   input  logic                 frame_ready,
   output logic                 scan_done,
   output logic                 overrun
);
   localparam int N  = ROWS * COLS;
   localparam int RW = $clog2(ROWS);
   localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam int DW = $clog2(DEBOUNCE + 1);

   localparam logic [RW-1:0]   LAST_ROW    = RW'(ROWS - 1);
   localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE);
   localparam logic [DW-1:0]   DEB_ZERO    = DW'(32'd0);
   localparam logic [DW-1:0]   DEB_ONE     = DW'(32'd1);
   localparam logic [DW-1:0]   DEB_MAX     = DW'(DEBOUNCE);
   localparam logic [ROWS-1:0] ROW_FIRST   = {{(ROWS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ROW  = 2'd1,
      ST_END  = 2'd2
   } state_t;

   state_t          state_r;
   logic [RW-1:0]   row_idx_r;
   logic [SW-1:0]   settle_cnt_r;
   logic [DW-1:0]   deb_cnt_r;
   logic            primed_r;
   logic [N-1:0]    raw_r;
   logic [N-1:0]    last_raw_r;

   logic [N-1:0]    raw_cap_s;
   logic [DW-1:0]   deb_next_s;
   logic            publish_s;
   logic            accept_s;

   assign accept_s = frame_valid & frame_ready;

   // Raw frame with the column bus merged into the slot of the row being driven.
   always_comb begin
      raw_cap_s = raw_r;
      for (int k = 0; k < ROWS; k++) begin
         if (row_idx_r == RW'(k)) begin
            raw_cap_s[(ROWS-k)*COLS-1 -: COLS] = c;
         end else begin
            raw_cap_s[(ROWS-k)*COLS-1 -: COLS] = raw_r[(ROWS-k)*COLS-1 -: COLS];
         end
      end
   end

   // Debounce count and publish decision for the frame just completed.
   always_comb begin
      deb_next_s = deb_cnt_r;
      publish_s  = 1'b0;
      if (deb_cnt_r == DEB_ZERO) begin
         deb_next_s = DEB_ONE;
      end else if (raw_r != last_raw_r) begin
         deb_next_s = DEB_ONE;
      end else if (deb_cnt_r == DEB_MAX) begin
         deb_next_s = DEB_MAX;
      end else begin
         deb_next_s = deb_cnt_r + DEB_ONE;
      end
      // The first stable frame after reset publishes even when it matches the reset frame.
      if ((deb_next_s == DEB_MAX) && (!primed_r || (raw_r != frame))) begin
         publish_s = 1'b1;
      end else begin
         publish_s = 1'b0;
      end
   end

   // Scan sequencing, debounce history and the publish/handshake registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         row_idx_r    <= {RW{1'b0}};
         settle_cnt_r <= {SW{1'b0}};
         deb_cnt_r    <= DEB_ZERO;
         primed_r     <= 1'b0;
         raw_r        <= {N{1'b0}};
         last_raw_r   <= {N{1'b0}};
         r            <= {ROWS{1'b0}};
         frame        <= {N{1'b0}};
         change_mask  <= {N{1'b0}};
         frame_valid  <= 1'b0;
         scan_done    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         overrun   <= 1'b0;
         if (accept_s) begin
            frame_valid <= 1'b0;
         end else begin
            frame_valid <= frame_valid;
         end
         case (state_r)
            ST_IDLE: begin
               row_idx_r    <= {RW{1'b0}};
               settle_cnt_r <= {SW{1'b0}};
               if (en) begin
                  state_r <= ST_ROW;
                  r       <= ROW_FIRST;
               end else begin
                  state_r <= ST_IDLE;
                  r       <= {ROWS{1'b0}};
               end
            end
            ST_ROW: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  settle_cnt_r <= {SW{1'b0}};
                  raw_r        <= raw_cap_s;
                  if (row_idx_r == LAST_ROW) begin
                     state_r <= ST_END;
                     r       <= {ROWS{1'b0}};
                  end else begin
                     row_idx_r <= row_idx_r + RW'(32'd1);
                     r         <= {r[ROWS-2:0], 1'b0};
                  end
               end else begin
                  settle_cnt_r <= settle_cnt_r + SW'(32'd1);
               end
            end
            ST_END: begin
               scan_done    <= 1'b1;
               deb_cnt_r    <= deb_next_s;
               last_raw_r   <= raw_r;
               row_idx_r    <= {RW{1'b0}};
               settle_cnt_r <= {SW{1'b0}};
               if (publish_s) begin
                  // Mask is taken against whatever frame is held, accepted or not.
                  change_mask <= raw_r ^ frame;
                  frame       <= raw_r;
                  primed_r    <= 1'b1;
                  frame_valid <= 1'b1;
                  overrun     <= frame_valid & ~frame_ready;
               end else begin
                  primed_r <= primed_r;
               end
               if (en) begin
                  state_r <= ST_ROW;
                  r       <= ROW_FIRST;
               end else begin
                  state_r <= ST_IDLE;
                  r       <= {ROWS{1'b0}};
               end
            end
            default: begin
               state_r <= ST_IDLE;
               r       <= {ROWS{1'b0}};
            end
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_scanner.sv
// Bench for matrix_scanner: a default 8x8 instance and a 4x6 SETTLE=3 DEBOUNCE=1 instance
// driven from board images, checked per frame against a history-based reference model.
module tb_matrix_scanner;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, rdy, sel, en_a, en_b;
   logic [63:0] board_a;
   logic [23:0] board_b;
   logic [7:0]  c_a, r_a;
   logic [5:0]  c_b;
   logic [3:0]  r_b;
   logic [63:0] frame_a, mask_a;
   logic [23:0] frame_b, mask_b;
   logic        fv_a, fv_b, done_a, done_b, ovr_a, ovr_b;

   matrix_scanner dut_a (
      .clk(clk), .reset(reset), .en(en_a), .c(c_a), .r(r_a), .frame(frame_a),
      .change_mask(mask_a), .frame_valid(fv_a), .frame_ready(rdy & ~sel),
      .scan_done(done_a), .overrun(ovr_a));

   matrix_scanner #(.ROWS(4), .COLS(6), .SETTLE(3), .DEBOUNCE(1)) dut_b (
      .clk(clk), .reset(reset), .en(en_b), .c(c_b), .r(r_b), .frame(frame_b),
      .change_mask(mask_b), .frame_valid(fv_b), .frame_ready(rdy & sel),
      .scan_done(done_b), .overrun(ovr_b));

   // The sensor grid: the column bus shows the driven row of the current board image.
   always_comb begin
      c_a = 8'h00;
      for (int k = 0; k < 8; k++) if (r_a[k]) c_a = board_a[(8-k)*8-1 -: 8];
      c_b = 6'h00;
      for (int k = 0; k < 4; k++) if (r_b[k]) c_b = board_b[(4-k)*6-1 -: 6];
   end

   logic [7:0]  obs_r;
   logic [63:0] obs_frame, obs_mask;
   logic        obs_valid, obs_done, obs_ovr;
   assign obs_r     = sel ? {4'h0, r_b} : r_a;
   assign obs_frame = sel ? {40'd0, frame_b} : frame_a;
   assign obs_mask  = sel ? {40'd0, mask_b} : mask_a;
   assign obs_valid = sel ? fv_b : fv_a;
   assign obs_done  = sel ? done_b : done_a;
   assign obs_ovr   = sel ? ovr_b : ovr_a;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: raw frames seen since reset, the published frame and handshake state.
   logic [63:0] hist[$];
   logic [63:0] cur_board, m_frame, m_mask;
   logic        m_primed, m_valid, m_ovr;

   task automatic model_reset();
      hist.delete();
      m_frame = 64'd0; m_mask = 64'd0; m_primed = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_frame(input logic [63:0] raw, input logic ready);
      int run, deb;
      logic pub;
      deb = sel ? 1 : 2;
      hist.push_back(raw);
      if (hist.size() > 8) void'(hist.pop_front());
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] == raw) run++;
         else break;
      end
      pub   = (run >= deb) && (!m_primed || raw != m_frame);
      m_ovr = pub && m_valid && !ready;
      m_valid = pub || (m_valid && !ready);
      if (pub) begin
         m_mask = raw ^ m_frame;
         m_frame = raw;
         m_primed = 1'b1;
      end
   endtask

   task automatic set_board(input logic [63:0] b);
      if (sel) begin board_b = b[23:0]; cur_board = {40'd0, b[23:0]}; end
      else begin board_a = b; cur_board = b; end
   endtask

   task automatic set_en(input logic v);
      if (sel) en_b = v; else en_a = v;
   endtask

   // Walks one frame from phase start_p to its scan_done cycle, checking r every cycle.
   task automatic run_frame(input int start_p, input int drop_p);
      int hold, rows, per;
      logic [7:0] exp_r;
      hold = sel ? 4 : 2;
      rows = sel ? 4 : 8;
      per  = rows * hold + 1;
      for (int p = start_p; p <= per; p++) begin
         @(negedge clk);
         if (p < per) begin
            exp_r = (p < rows * hold) ? (8'd1 << (p / hold)) : 8'd0;
            n_cmp++;
            if (obs_r !== exp_r) begin
               n_bad++; $display("FAIL r_walk p=%0d: got %h expected %h", p, obs_r, exp_r);
            end
            n_cmp++;
            if (obs_done !== 1'b0) begin
               n_bad++; $display("FAIL scan_done_early p=%0d: got %b expected 0", p, obs_done);
            end
            if (p == drop_p) set_en(1'b0);
         end else begin
            n_cmp++;
            if (obs_done !== 1'b1) begin
               n_bad++; $display("FAIL scan_done_period: got %b expected 1", obs_done);
            end
            model_frame(cur_board, rdy);
            n_cmp++;
            if (obs_valid !== m_valid) begin
               n_bad++; $display("FAIL frame_valid: got %b expected %b", obs_valid, m_valid);
            end
            n_cmp++;
            if (obs_frame !== m_frame) begin
               n_bad++; $display("FAIL frame: got %h expected %h", obs_frame, m_frame);
            end
            n_cmp++;
            if (obs_mask !== m_mask) begin
               n_bad++; $display("FAIL change_mask: got %h expected %h", obs_mask, m_mask);
            end
            n_cmp++;
            if (obs_ovr !== m_ovr) begin
               n_bad++; $display("FAIL overrun: got %b expected %b", obs_ovr, m_ovr);
            end
         end
      end
   endtask

   task automatic frame_step(input logic [63:0] b);
      set_board(b);
      run_frame(1, -1);
   endtask

   localparam logic [63:0] B0 = 64'hFFFF_0000_0000_FFFF;
   localparam logic [63:0] B1 = 64'hFFF7_0000_0000_FFFF;

   task automatic test_reset();
      sel = 1'b0; rdy = 1'b0; en_a = 1'b0; en_b = 1'b0; board_a = 64'd0; board_b = 24'd0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({r_a, fv_a, done_a, ovr_a, r_b, fv_b, done_b, ovr_b} !== 22'd0) begin
         n_bad++; $display("FAIL reset_ctrl: got %h expected 0", {r_a, fv_a, done_a, ovr_a, r_b, fv_b, done_b, ovr_b});
      end
      n_cmp++;
      if ({frame_a, mask_a, frame_b, mask_b} !== 176'd0) begin
         n_bad++; $display("FAIL reset_data: got %h %h expected 0", frame_a, mask_a);
      end
      reset = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (r_a !== 8'h00 || done_a !== 1'b0) begin
         n_bad++; $display("FAIL idle_no_en: got r=%h done=%b expected 00/0", r_a, done_a);
      end
   endtask

   task automatic test_scan_walk();
      set_board(B0);
      set_en(1'b1);
      run_frame(0, -1);
      frame_step(B0);
      n_cmp++;
      if (obs_frame !== 64'hFFFF_0000_0000_FFFF || obs_mask !== 64'hFFFF_0000_0000_FFFF || obs_valid !== 1'b1) begin
         n_bad++; $display("FAIL first_publish: got %h/%h/%b expected FFFF00000000FFFF both, valid 1", obs_frame, obs_mask, obs_valid);
      end
   endtask

   task automatic test_accept_static();
      rdy = 1'b1;
      repeat (5) frame_step(B0);
   endtask

   task automatic test_glitch();
      frame_step(B1);
      frame_step(B0);
      frame_step(B0);
      n_cmp++;
      if (obs_frame !== B0 || obs_valid !== 1'b0) begin
         n_bad++; $display("FAIL glitch: got %h valid %b expected %h valid 0", obs_frame, obs_valid, B0);
      end
   endtask

   task automatic test_move();
      frame_step(B1);
      frame_step(B1);
      n_cmp++;
      if (obs_mask !== 64'h0008_0000_0000_0000 || obs_valid !== 1'b1) begin
         n_bad++; $display("FAIL move_mask: got %h valid %b expected 0008000000000000 valid 1", obs_mask, obs_valid);
      end
      frame_step(B1);
   endtask

   task automatic test_overrun();
      logic [63:0] b2, b3;
      b2 = B1 ^ 64'h0000_0000_0001_0000;
      b3 = b2 & ~64'h0000_0000_0000_0001;
      rdy = 1'b0;
      frame_step(b2);
      frame_step(b2);
      frame_step(b3);
      frame_step(b3);
      n_cmp++;
      if (obs_frame !== b3 || obs_valid !== 1'b1 || obs_ovr !== 1'b1) begin
         n_bad++; $display("FAIL overrun_latest: got %h v=%b o=%b expected %h v=1 o=1", obs_frame, obs_valid, obs_ovr, b3);
      end
      rdy = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (obs_valid !== 1'b0 || obs_ovr !== 1'b0) begin
         n_bad++; $display("FAIL accept_clear: got v=%b o=%b expected 0/0", obs_valid, obs_ovr);
      end
      m_valid = 1'b0;
      run_frame(2, -1);
   endtask

   task automatic test_random_a();
      logic [63:0] b;
      int nh;
      b = cur_board;
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 2) != 0) b = {$urandom(), $urandom()};
         nh = $urandom_range(1, 3);
         for (int h = 0; h < nh; h++) begin
            rdy = 1'($urandom_range(0, 1));
            frame_step(b);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] b4;
      b4 = {$urandom(), $urandom()} ^ cur_board;
      rdy = 1'b0;
      frame_step(b4);
      frame_step(b4);
      for (int p = 1; p <= 6; p++) @(negedge clk);
      n_cmp++;
      if (r_a !== 8'h08 || fv_a !== 1'b1) begin
         n_bad++; $display("FAIL pre_reset: got r=%h v=%b expected 08/1", r_a, fv_a);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({r_a, fv_a, done_a, ovr_a} !== 11'd0 || frame_a !== 64'd0 || mask_a !== 64'd0) begin
         n_bad++; $display("FAIL async_reset: got r=%h v=%b f=%h m=%h expected all 0", r_a, fv_a, frame_a, mask_a);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      set_board(64'd0);
      run_frame(0, -1);
      frame_step(64'd0);
      n_cmp++;
      if (fv_a !== 1'b1 || frame_a !== 64'd0 || mask_a !== 64'd0) begin
         n_bad++; $display("FAIL zero_publish: got v=%b f=%h m=%h expected 1/0/0", fv_a, frame_a, mask_a);
      end
   endtask

   task automatic test_config_b();
      logic [63:0] b;
      sel = 1'b1;
      rdy = 1'b0;
      model_reset();
      set_board({40'd0, 24'($urandom())});
      set_en(1'b1);
      run_frame(0, -1);
      n_cmp++;
      if (fv_b !== 1'b1 || frame_b !== cur_board[23:0]) begin
         n_bad++; $display("FAIL b_first_scan: got v=%b f=%h expected 1/%h", fv_b, frame_b, cur_board[23:0]);
      end
      for (int i = 0; i < 6; i++) begin
         b = (i == 2) ? cur_board : {40'd0, 24'($urandom())};
         rdy = 1'($urandom_range(0, 1));
         frame_step(b);
      end
      rdy = 1'b1;
      set_board({40'd0, 24'($urandom())});
      run_frame(1, 7);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         n_cmp++;
         if (r_b !== 4'h0 || done_b !== 1'b0) begin
            n_bad++; $display("FAIL b_idle: got r=%h done=%b expected 0/0", r_b, done_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_walk();
      test_accept_static();
      test_glitch();
      test_move();
      test_overrun();
      test_random_a();
      test_reset_mid();
      test_config_b();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
